// File: rtl/sn_pkg.sv
// -----------------------------------------------------------------------------
// sn_pkg
// Shared definitions for the stochastic-number accumulator bank.
//   DIM_DEF      default number of stochastic lanes
//   NUM_BIT_DEF  default per-lane count width
//   IDLE/ACC/HOLD state constants and the sn_state_e enum built from them
// -----------------------------------------------------------------------------
package sn_pkg;

    localparam int DIM_DEF     = 10;
    localparam int NUM_BIT_DEF = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_ACC  = ACC,
        ST_HOLD = HOLD
    } sn_state_e;

endpackage

// File: rtl/sn_lane_counter.sv
// -----------------------------------------------------------------------------
// sn_lane_counter
// One saturating lane counter. Load takes the incoming bit as the first
// sample of a stream; inc adds the bit, sticking at all-ones.
// Ports:
//   i_clk_fsm_mux  clock (rising edge)
//   i_rst_fsm_mux  asynchronous active-high reset
//   clr            synchronous clear to zero (highest priority)
//   load           start a new count with sn_bit
//   inc            accumulate sn_bit
//   sn_bit         stochastic bit for this lane
//   cnt            current count
// -----------------------------------------------------------------------------
module sn_lane_counter #(
    parameter int W = 8
) (
    input  logic         i_clk_fsm_mux,
    input  logic         i_rst_fsm_mux,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    input  logic         sn_bit,
    output logic [W-1:0] cnt
);

    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= {{(W-1){1'b0}}, sn_bit};
        else if (inc && sn_bit && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sn_acc_bank.sv
// -----------------------------------------------------------------------------
// sn_acc_bank
// Converts DIM parallel stochastic bit streams into binary ones-counts plus
// the stream length, then holds the result under a valid/ready handshake.
// Ports:
//   i_clk_fsm_mux  clock (rising edge)
//   i_rst_fsm_mux  asynchronous active-high reset
//   i_isgen        stream-active qualifier
//   i_sn_bit[DIM]  stochastic bit per lane, used only while i_isgen=1
//   i_clear        synchronous flush, beats every other event
//   i_ready        downstream accepts the held result
//   o_valid        result held and valid
//   o_bn[DIM]      saturating ones-count per lane
//   o_len          saturating number of i_isgen=1 cycles
//   o_drop_cnt     (only with SN_ACC_DROP_CNT_EN) streams dropped while a
//                  result was held, saturating at 255
// Build option: define SN_ACC_DROP_CNT_EN to add the drop counter.
// -----------------------------------------------------------------------------
module sn_acc_bank
    import sn_pkg::*;
#(
    parameter int DIM     = DIM_DEF,
    parameter int NUM_BIT = NUM_BIT_DEF
) (
    input  logic               i_clk_fsm_mux,
    input  logic               i_rst_fsm_mux,
    input  logic               i_isgen,
    input  logic               i_sn_bit [DIM-1:0],
    input  logic               i_clear,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [NUM_BIT-1:0] o_bn [DIM-1:0],
`ifdef SN_ACC_DROP_CNT_EN
    output logic [7:0]         o_drop_cnt,
`endif
    output logic [NUM_BIT:0]   o_len
);

    sn_state_e state, nxt_state;
    logic      isgen_q;     // i_isgen one cycle ago
    logic      drop_act;    // current i_isgen run belongs to a dropped stream
    logic      drop_nxt;
    logic      cnt_load;
    logic      cnt_inc;
    logic      fresh_ok;

    // A stream may start unless we are still inside the tail of a dropped
    // one; that tail only ends when i_isgen falls.
    assign fresh_ok = !(drop_act && isgen_q);

    always_comb begin
        nxt_state = state;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        drop_nxt  = drop_act;
        if (i_clear) begin
            nxt_state = ST_IDLE;
            drop_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_isgen && fresh_ok) begin
                        nxt_state = ST_ACC;
                        cnt_load  = 1'b1;
                    end
                end
                ST_ACC: begin
                    if (i_isgen) cnt_inc = 1'b1;
                    else         nxt_state = ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        // zero-bubble restart when a clean stream begins now
                        if (i_isgen && fresh_ok) begin
                            nxt_state = ST_ACC;
                            cnt_load  = 1'b1;
                        end else begin
                            nxt_state = ST_IDLE;
                        end
                    end else if (i_isgen) begin
                        drop_nxt = 1'b1;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
            if (!i_isgen) drop_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux) begin
            state    <= ST_IDLE;
            isgen_q  <= 1'b0;
            drop_act <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            state    <= nxt_state;
            isgen_q  <= i_isgen;
            drop_act <= drop_nxt;
            o_valid  <= (nxt_state == ST_HOLD);
        end
    end

    // Stream length, saturating one bit wider than the lane counts.
    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux)
            o_len <= '0;
        else if (i_clear)
            o_len <= '0;
        else if (cnt_load)
            o_len <= {{NUM_BIT{1'b0}}, 1'b1};
        else if (cnt_inc && (o_len != {(NUM_BIT+1){1'b1}}))
            o_len <= o_len + 1'b1;
    end

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        sn_lane_counter #(.W(NUM_BIT)) u_lane (
            .i_clk_fsm_mux (i_clk_fsm_mux),
            .i_rst_fsm_mux (i_rst_fsm_mux),
            .clr           (i_clear),
            .load          (cnt_load),
            .inc           (cnt_inc),
            .sn_bit        (i_sn_bit[g]),
            .cnt           (o_bn[g])
        );
    end

`ifdef SN_ACC_DROP_CNT_EN
    // Count each dropped stream once, on its rising i_isgen edge.
    logic drop_start;
    assign drop_start = (state == ST_HOLD) && !i_ready && i_isgen && !isgen_q;

    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux)
            o_drop_cnt <= '0;
        else if (i_clear)
            o_drop_cnt <= '0;
        else if (drop_start && (o_drop_cnt != 8'hFF))
            o_drop_cnt <= o_drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sn_acc_bank.sv
// -----------------------------------------------------------------------------
// tb_sn_acc_bank
// Directed scenarios plus randomized traffic against a stream-level model:
// each accepted stream is recorded as a queue of lane vectors and its result
// is the saturated per-lane popcount and length of that queue.
// Build option: define SN_ACC_DROP_CNT_EN to also check o_drop_cnt.
// -----------------------------------------------------------------------------
module tb_sn_acc_bank;

    localparam int DIM = 10;
    localparam int NB  = 8;
    localparam int BN_MAX  = (1 << NB) - 1;
    localparam int LEN_MAX = (1 << (NB + 1)) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          isgen = 1'b0;
    logic          sn [DIM-1:0];
    logic          clear = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [NB-1:0] bn [DIM-1:0];
    logic [NB:0]   len;
`ifdef SN_ACC_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    always #5 clk = ~clk;

    sn_acc_bank #(.DIM(DIM), .NUM_BIT(NB)) dut (
        .i_clk_fsm_mux (clk),
        .i_rst_fsm_mux (rst),
        .i_isgen       (isgen),
        .i_sn_bit      (sn),
        .i_clear       (clear),
        .i_ready       (ready),
        .o_valid       (valid),
        .o_bn          (bn),
`ifdef SN_ACC_DROP_CNT_EN
        .o_drop_cnt    (drop_cnt),
`endif
        .o_len         (len)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (stream level) ----------------
    bit               m_valid, m_in, m_ign, m_zero, m_prev;
    int               m_bn [DIM];
    int               m_len, m_drops;
    logic [DIM-1:0]   m_q [$];

    task automatic m_reset();
        m_valid = 0; m_in = 0; m_ign = 0; m_zero = 1; m_prev = 0;
        m_drops = 0; m_len = 0; m_q.delete();
        foreach (m_bn[i]) m_bn[i] = 0;
    endtask

    task automatic m_start(input logic [DIM-1:0] b);
        m_q.delete();
        m_q.push_back(b);
        m_in = 1; m_zero = 0;
    endtask

    task automatic m_finish();
        foreach (m_bn[i]) begin
            int s = 0;
            foreach (m_q[k]) s += int'(m_q[k][i]);
            m_bn[i] = (s > BN_MAX) ? BN_MAX : s;
        end
        m_len   = (m_q.size() > LEN_MAX) ? LEN_MAX : m_q.size();
        m_in    = 0;
        m_valid = 1;
    endtask

    task automatic m_edge(input logic g, input logic [DIM-1:0] b, input logic r, input logic c);
        if (c) begin
            m_reset();
        end else if (m_valid) begin
            if (r) begin
                m_valid = 0;
                if (g && !m_ign) m_start(b);
            end else if (g) begin
                if (!m_prev && m_drops < 255) m_drops++;
                m_ign = 1;
            end
        end else if (m_in) begin
            if (g) m_q.push_back(b);
            else   m_finish();
        end else if (g && !m_ign) begin
            m_start(b);
        end
        if (!g) m_ign = 0;
        m_prev = g;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
        if (m_valid || m_zero) begin
            for (int i = 0; i < DIM; i++)
                chk($sformatf("%s_bn%0d", tag, i), 32'(bn[i]), 32'(m_bn[i]));
            chk({tag, "_len"}, 32'(len), 32'(m_len));
        end
`ifdef SN_ACC_DROP_CNT_EN
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check after.
    task automatic step(input string tag, input logic g, input logic [DIM-1:0] b,
                        input logic r, input logic c);
        isgen = g; ready = r; clear = c;
        for (int i = 0; i < DIM; i++) sn[i] = b[i];
        @(posedge clk);
        m_edge(g, b, r, c);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        isgen = 0; ready = 0; clear = 0;
        rst = 1;
        #1;
        m_reset();
        check_all(tag);   // reset is asynchronous: outputs clear with no edge
        @(posedge clk); @(posedge clk);
        #1 rst = 0;
    endtask

    function automatic logic [DIM-1:0] rnd_bits();
        return DIM'($urandom());
    endfunction

    initial begin
        logic [DIM-1:0] b;
        logic g, r, c;
        for (int i = 0; i < DIM; i++) sn[i] = 1'b0;
        m_reset();
        @(posedge clk);
        do_reset("rst0");

        // 256-cycle stream: lane0 ones except last, lane1 zeros
        for (int k = 0; k < 256; k++) begin
            b = rnd_bits();
            b[0] = (k != 255);
            b[1] = 1'b0;
            step("s256", 1, b, 0, 0);
        end
        step("s256_end", 0, rnd_bits(), 0, 0);
        chk("r030_valid", 32'(valid), 1);
        chk("r030_bn0", 32'(bn[0]), 255);
        chk("r030_bn1", 32'(bn[1]), 0);
        chk("r030_len", 32'(len), 256);
        step("s256_acc", 0, '0, 1, 0);
        chk("r030_acc_valid", 32'(valid), 0);

        // 4-cycle stream, lane2 = 1,0,1,1, held 5 cycles before accept
        begin
            logic [3:0] pat;
            pat = 4'b1101;
            for (int k = 0; k < 4; k++) begin
                b = rnd_bits();
                b[2] = pat[k];
                step("s4", 1, b, 0, 0);
            end
        end
        for (int k = 0; k < 6; k++) begin
            step("s4_hold", 0, rnd_bits(), 0, 0);
            chk("r031_bn2", 32'(bn[2]), 3);
            chk("r031_len", 32'(len), 4);
        end
        step("s4_acc", 0, '0, 1, 0);
        chk("r031_valid_drop", 32'(valid), 0);

        // held result, 10-cycle stream arrives while not ready -> dropped
        step("clr", 0, '0, 0, 1);
        for (int k = 0; k < 3; k++) step("s3", 1, rnd_bits(), 0, 0);
        step("s3_end", 0, '0, 0, 0);
        for (int k = 0; k < 10; k++) step("drop10", 1, rnd_bits(), 0, 0);
        step("drop10_end", 0, rnd_bits(), 0, 0);
        chk("r032_len", 32'(len), 3);
`ifdef SN_ACC_DROP_CNT_EN
        chk("r032_drop", 32'(drop_cnt), 1);
`endif
        // drop in progress, ready rises mid-stream: stays dropped
        for (int k = 0; k < 3; k++) step("drop_mid", 1, rnd_bits(), 0, 0);
        for (int k = 0; k < 3; k++) step("drop_mid_acc", 1, rnd_bits(), 1, 0);
        chk("r021_idle", 32'(valid), 0);
        step("gap", 0, '0, 1, 0);

        // zero-bubble: accept in the same cycle the next stream starts
        for (int k = 0; k < 5; k++) step("zb1", 1, rnd_bits(), 0, 0);
        step("zb1_end", 0, '0, 0, 0);
        step("zb2_start", 1, '1, 1, 0);
        step("zb2", 1, '1, 0, 0);
        step("zb2_end", 0, '0, 0, 0);
        chk("r033_len", 32'(len), 2);
        chk("r033_bn0", 32'(bn[0]), 2);
        step("zb2_acc", 0, '0, 1, 0);

        // clear mid-ACC at cycle 7, then a fresh stream
        for (int k = 0; k < 7; k++) step("pre_clr", 1, rnd_bits(), 0, 0);
        step("clr_mid", 1, rnd_bits(), 1, 1);
        chk("r034_clr_len", 32'(len), 0);
        step("clr_gap", 0, '0, 0, 0);
        for (int k = 0; k < 4; k++) step("post_clr", 1, '1, 0, 0);
        step("post_clr_end", 0, '0, 0, 0);
        chk("r034_clr_next", 32'(len), 4);
        step("post_clr_acc", 0, '0, 1, 0);

        // reset mid-ACC at cycle 7, then a fresh stream
        for (int k = 0; k < 7; k++) step("pre_rst", 1, rnd_bits(), 0, 0);
        do_reset("rst_mid");
        for (int k = 0; k < 2; k++) step("post_rst", 1, '1, 0, 0);
        step("post_rst_end", 0, '0, 0, 0);
        chk("r034_rst_next", 32'(len), 2);
        step("post_rst_acc", 0, '0, 1, 0);

        // length saturation: 520 cycles of all ones
        for (int k = 0; k < 520; k++) step("sat", 1, '1, 0, 0);
        step("sat_end", 0, '0, 0, 0);
        chk("r016_len", 32'(len), LEN_MAX);
        chk("r016_bn", 32'(bn[5]), BN_MAX);
        step("sat_acc", 0, '0, 1, 0);

        // randomized traffic
        g = 0;
        for (int k = 0; k < 3000; k++) begin
            if (g) g = ($urandom_range(0, 5) != 0);
            else   g = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 99) == 0);
            step("rnd", g, rnd_bits(), r, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sn_acc_bank.md
SN_ACC_BANK -- requirements
Module: sn_acc_bank

Interface
REQ-001 Parameter DIM, default 10, number of stochastic lanes.
REQ-002 Parameter NUM_BIT, default 8, count width per lane.
REQ-003 i_clk_fsm_mux  input  1  clock; all state SHALL update on its rising edge.
REQ-004 i_rst_fsm_mux  input  1  reset, asynchronous, active-high.
REQ-005 i_isgen  input  1  stream-active qualifier from the stochastic generator stage.
REQ-006 i_sn_bit  input  1 x DIM (unpacked)  stochastic bit per lane, meaningful only when i_isgen=1.
REQ-007 i_clear  input  1  synchronous abort/flush.
REQ-008 i_ready  input  1  downstream accepts result.
REQ-009 o_valid  output  1  result held and valid.
REQ-010 o_bn  output  NUM_BIT x DIM (unpacked)  ones-count per lane.
REQ-011 o_len  output  NUM_BIT+1  number of i_isgen=1 cycles in the stream.

Function
REQ-012 States SHALL be IDLE, ACC, HOLD; all outputs registered.
REQ-013 IDLE: i_isgen=1 -> ACC; lane counts SHALL load i_sn_bit[i], length SHALL load 1 on that edge.
REQ-014 ACC: each cycle with i_isgen=1, lane count i SHALL add i_sn_bit[i]; length SHALL add 1.
REQ-015 ACC: first cycle with i_isgen=0 -> HOLD; o_valid SHALL be 1 from the next edge (one cycle after the stream ends).
REQ-016 Lane counts SHALL saturate at 2^NUM_BIT-1; length SHALL saturate at 2^(NUM_BIT+1)-1; no wrap.
REQ-017 HOLD: o_bn, o_len SHALL stay stable while o_valid=1 and i_ready=0.
REQ-018 HOLD with i_ready=1, i_isgen=0: -> IDLE, o_valid=0 next cycle.
REQ-019 HOLD with i_ready=1, i_isgen=1: -> ACC directly, counters reloaded per REQ-013 (zero-bubble).
REQ-020 HOLD with i_ready=0, i_isgen=1: the new stream SHALL be dropped whole; held result unchanged; state remains HOLD until accepted.
REQ-021 A stream dropped per REQ-020 SHALL stay dropped even if i_ready rises mid-stream; acceptance in that case -> IDLE and the next stream SHALL begin only on a fresh 0->1 i_isgen transition.
REQ-022 i_clear=1 SHALL force IDLE, zero all counts, o_valid=0 next cycle; it SHALL take priority over every other event, including a handshake in the same cycle.
REQ-023 i_sn_bit SHALL be ignored whenever i_isgen=0.

Reset
REQ-024 Asserting i_rst_fsm_mux SHALL immediately force IDLE, o_valid=0, o_bn all zero, o_len=0, internal previous-isgen register=0.
REQ-025 Reset mid-stream SHALL discard the partial result; after release a new stream SHALL require i_isgen=1 in IDLE.

Configuration
REQ-026 Macro SN_ACC_DROP_CNT_EN defined: output o_drop_cnt (8 bits, reset 0) SHALL increment once per stream dropped under REQ-020/021, counted on the 0->1 i_isgen edge, saturating at 255, cleared by i_clear.
REQ-027 Macro undefined: no o_drop_cnt port and no drop-count logic; all other behaviour identical.

Structure
REQ-028 Shared package sn_pkg SHALL hold DIM, NUM_BIT defaults and the state enum typedef (IDLE, ACC, HOLD).
REQ-029 Sub-module sn_lane_counter SHALL implement one saturating load/increment lane counter, instantiated DIM times via generate.

Verification
REQ-030 256-cycle stream, lane 0 all ones except final cycle 0, lane 1 all zeros -> o_bn[0]=255, o_bn[1]=0, o_len=256, o_valid one cycle after i_isgen falls.
REQ-031 Stream of 4 cycles, lane 2 bits 1,0,1,1; i_ready held 0 for 5 cycles then 1 -> o_bn[2]=3, o_len=4 stable throughout, o_valid drops the cycle after acceptance.
REQ-032 Result held, new 10-cycle stream while i_ready=0 -> held values unchanged; o_drop_cnt=1 with SN_ACC_DROP_CNT_EN.
REQ-033 i_ready=1 in same cycle new stream starts -> no bubble; second result reflects only the second stream.
REQ-034 i_clear and reset asserted mid-ACC (cycle 7) -> IDLE, o_valid=0, all counts 0; next stream counted from zero.
